// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshakes, a wait watchdog and a retired-instruction counter. Optional macro: ILLEGAL_TRAP_EN.
module mc_ctrl #(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 255,
    parameter int RET_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               imem_req,
    input  logic               imem_ready,
    output logic               dmem_req,
    input  logic               dmem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               EXTOp,
    output logic               ALUSrc,
    output logic               AregSel,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic [2:0]         state,
    output logic [RET_W-1:0]   instret,
    output logic               err
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                           ALU_OR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_NOR = 4'd10, ALU_XOR = 4'd11,
                           ALU_LUI = 4'd12;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      cur, nxt;
    logic [15:0] wait_cnt;
    logic        retire, wait_cyc, timeout;

    logic       legal, is_r, alu_src, ext_op, areg_sel;
    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
    logic [3:0] alu_code;

    assign state = cur;

    always_comb begin
        legal = 1'b1; is_r = 1'b0; alu_src = 1'b0; ext_op = 1'b0; areg_sel = 1'b0;
        is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
        is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_jalr = 1'b0;
        alu_code = ALU_NOP;
        case (Op)
            6'b000000: begin
                is_r = 1'b1;
                case (Funct)
                    6'b100000, 6'b100001: alu_code = ALU_ADD;
                    6'b100010, 6'b100011: alu_code = ALU_SUB;
                    6'b100100: alu_code = ALU_AND;
                    6'b100101: alu_code = ALU_OR;
                    6'b100110: alu_code = ALU_XOR;
                    6'b100111: alu_code = ALU_NOR;
                    6'b101010: alu_code = ALU_SLT;
                    6'b101011: alu_code = ALU_SLTU;
                    6'b000000: begin alu_code = ALU_SLL; areg_sel = 1'b1; end
                    6'b000010: begin alu_code = ALU_SRL; areg_sel = 1'b1; end
                    6'b000011: begin alu_code = ALU_SRA; areg_sel = 1'b1; end
                    6'b000100: alu_code = ALU_SLL;
                    6'b000110: alu_code = ALU_SRL;
                    6'b001000: is_jr = 1'b1;
                    6'b001001: is_jalr = 1'b1;
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000: begin alu_code = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; end
            6'b001100: begin alu_code = ALU_AND;  alu_src = 1'b1; end
            6'b001101: begin alu_code = ALU_OR;   alu_src = 1'b1; end
            6'b001010: begin alu_code = ALU_SLT;  alu_src = 1'b1; ext_op = 1'b1; end
            6'b001111: begin alu_code = ALU_LUI;  alu_src = 1'b1; end
            6'b100011: begin alu_code = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; is_lw = 1'b1; end
            6'b101011: begin alu_code = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; is_sw = 1'b1; end
            6'b000100: begin alu_code = ALU_SUB;  ext_op = 1'b1; is_beq = 1'b1; end
            6'b000101: begin alu_code = ALU_SUB;  ext_op = 1'b1; is_bne = 1'b1; end
            6'b000010: is_j = 1'b1;
            6'b000011: is_jal = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt = cur; retire = 1'b0; wait_cyc = 1'b0; timeout = 1'b0;
        imem_req = 1'b0; dmem_req = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
        RegWrite = 1'b0; MemWrite = 1'b0; EXTOp = 1'b0; ALUSrc = 1'b0; AregSel = 1'b0;
        ALUOp = '0; NPCOp = 2'b00; GPRSel = 2'b00; WDSel = 2'b00;
        if (cur inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            ALUOp = ALUOP_W'(alu_code); ALUSrc = alu_src; EXTOp = ext_op; AregSel = areg_sel;
        end
        case (cur)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWrite = 1'b1; PCWrite = 1'b1; nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) nxt = S_EXEC;
                else begin
`ifdef ILLEGAL_TRAP_EN
                    nxt = S_TRAP;
`else
                    nxt = S_FETCH; retire = 1'b1;
`endif
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) nxt = S_MEM;
                else if (is_beq || is_bne) begin
                    if ((is_beq && Zero) || (is_bne && !Zero)) begin
                        PCWrite = 1'b1; NPCOp = 2'b01;
                    end
                    nxt = S_FETCH; retire = 1'b1;
                end else if (is_j || is_jal || is_jr || is_jalr) begin
                    PCWrite = 1'b1;
                    NPCOp = (is_jr || is_jalr) ? 2'b11 : 2'b10;
                    if (is_jal || is_jalr) begin
                        RegWrite = 1'b1; WDSel = 2'b10; GPRSel = is_jal ? 2'b10 : 2'b00;
                    end
                    nxt = S_FETCH; retire = 1'b1;
                end else nxt = S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1; MemWrite = is_sw;
                if (dmem_ready) begin
                    nxt = is_sw ? S_FETCH : S_WB; retire = is_sw;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                GPRSel = is_r ? 2'b00 : 2'b01;
                WDSel = is_lw ? 2'b01 : 2'b00;
                nxt = S_FETCH; retire = 1'b1;
            end
            S_HALT, S_TRAP: ;
            default: nxt = S_FETCH;
        endcase
        // A handshake still waiting on its last allowed cycle ends in HALT; ready in that cycle wins.
        wait_cyc = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);
        timeout = wait_cyc && (wait_cnt == TMO_LAST);
        if (timeout) nxt = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_FETCH;
            instret  <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal  <= 1'b0;
`endif
        end else begin
            cur <= nxt;
            if (retire) instret <= instret + RET_W'(1);
            if (timeout) err <= 1'b1;
            if (wait_cyc && nxt == cur) wait_cnt <= wait_cnt + 16'd1;
            else wait_cnt <= '0;
`ifdef ILLEGAL_TRAP_EN
            if (nxt == S_TRAP) illegal <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: instruction table expanded into per-cycle expected control words,
// queued at drive time and compared at the following falling edge, plus reset/timeout sequences.
module tb_mc_ctrl;

    localparam int K_ALU_R = 0, K_ALU_I = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                   K_J = 5, K_JAL = 6, K_JR = 7, K_JALR = 8, K_BAD = 9;

    logic       clk, rst, Zero, imem_ready, dmem_ready;
    logic [5:0] Op, Funct;
    logic       imem_req, dmem_req, PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUSrc, AregSel, err;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp, GPRSel, WDSel;
    logic [2:0] state;
    logic [2:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    mc_ctrl #(.ALUOP_W(4), .TIMEOUT(4), .RET_W(3)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .EXTOp(EXTOp), .ALUSrc(ALUSrc), .AregSel(AregSel), .ALUOp(ALUOp),
        .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
        .state(state), .instret(instret), .err(err)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, dreq, pcw, irw, rw, mw;
        logic [1:0] npc, gpr, wds;
        logic [3:0] alu;
        logic       src, ext, areg, err;
    } snap_t;

    typedef struct {
        snap_t v;
        snap_t m;
        string tag;
    } exp_t;

    typedef struct {
        string      name;
        logic [5:0] op, funct;
        logic       zero;
        int         kind;
        logic [3:0] alu;
        logic       src, ext, areg, taken;
        int         idly, ddly;
    } instr_t;

    exp_t   q[$];
    instr_t tbl[$];
    int     n_vec = 0;
    int     n_miss = 0;
    logic [2:0] exp_ret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic snap_t dut_snap();
        snap_t s;
        s.st = state; s.ireq = imem_req; s.dreq = dmem_req; s.pcw = PCWrite; s.irw = IRWrite;
        s.rw = RegWrite; s.mw = MemWrite; s.npc = NPCOp; s.gpr = GPRSel; s.wds = WDSel;
        s.alu = ALUOp; s.src = ALUSrc; s.ext = EXTOp; s.areg = AregSel; s.err = err;
        return s;
    endfunction

    function automatic instr_t mk(string name, logic [5:0] op, logic [5:0] funct, logic zero, int kind,
                                  logic [3:0] alu, logic src, logic ext, logic areg, logic taken,
                                  int idly, int ddly);
        instr_t t;
        t.name = name; t.op = op; t.funct = funct; t.zero = zero; t.kind = kind; t.alu = alu;
        t.src = src; t.ext = ext; t.areg = areg; t.taken = taken; t.idly = idly; t.ddly = ddly;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, act, want);
        end
    endtask

    // Drive one cycle, queue its expected control word, compare on the falling edge.
    task automatic cycle(input logic ir, input logic dr, input snap_t e, input snap_t m, input string tag);
        exp_t x;
        snap_t act;
        imem_ready = ir;
        dmem_ready = dr;
        q.push_back('{e, m, tag});
        @(negedge clk);
        x = q.pop_front();
        act = dut_snap();
        n_vec++;
        if (((act ^ x.v) & x.m) != '0) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (mask %h)", x.tag, act, x.v, x.m);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input instr_t t);
        snap_t s, m_ctl, m_all;
        m_all = '1;
        m_ctl = '1; m_ctl.alu = '0; m_ctl.src = 1'b0; m_ctl.ext = 1'b0; m_ctl.areg = 1'b0;
        Op = t.op; Funct = t.funct; Zero = t.zero;
        for (int i = 0; i < t.idly; i++) begin
            s = '0; s.ireq = 1'b1;
            cycle(1'b0, 1'b0, s, m_ctl, {t.name, "/FWAIT"});
        end
        s = '0; s.ireq = 1'b1; s.pcw = 1'b1; s.irw = 1'b1;
        cycle(1'b1, 1'b0, s, m_ctl, {t.name, "/FETCH"});
        s = '0; s.st = 3'd1;
        cycle(1'b0, 1'b0, s, m_ctl, {t.name, "/DECODE"});
        if (t.kind == K_BAD) begin
`ifdef ILLEGAL_TRAP_EN
            s = '0; s.st = 3'd6;
            cycle(1'b0, 1'b0, s, m_ctl, {t.name, "/TRAP"});
            chk({t.name, "/illegal"}, 32'(illegal), 32'd1);
`else
            exp_ret = exp_ret + 3'd1;
            chk({t.name, "/state_after"}, 32'(state), 32'd0);
`endif
        end else begin
            s = '0; s.st = 3'd2; s.alu = t.alu; s.src = t.src; s.ext = t.ext; s.areg = t.areg;
            case (t.kind)
                K_BR:   if (t.taken) begin s.pcw = 1'b1; s.npc = 2'b01; end
                K_J:    begin s.pcw = 1'b1; s.npc = 2'b10; end
                K_JAL:  begin s.pcw = 1'b1; s.npc = 2'b10; s.rw = 1'b1; s.gpr = 2'b10; s.wds = 2'b10; end
                K_JR:   begin s.pcw = 1'b1; s.npc = 2'b11; end
                K_JALR: begin s.pcw = 1'b1; s.npc = 2'b11; s.rw = 1'b1; s.gpr = 2'b00; s.wds = 2'b10; end
                default: ;
            endcase
            cycle(1'b0, 1'b0, s, m_all, {t.name, "/EXEC"});
            if (t.kind == K_LW || t.kind == K_SW) begin
                s = '0; s.st = 3'd3; s.dreq = 1'b1; s.mw = (t.kind == K_SW);
                for (int i = 0; i < t.ddly; i++) cycle(1'b0, 1'b0, s, m_ctl, {t.name, "/MWAIT"});
                cycle(1'b0, 1'b1, s, m_ctl, {t.name, "/MEM"});
            end
            if (t.kind == K_ALU_R || t.kind == K_ALU_I || t.kind == K_LW) begin
                s = '0; s.st = 3'd4; s.rw = 1'b1;
                s.gpr = (t.kind == K_ALU_R) ? 2'b00 : 2'b01;
                s.wds = (t.kind == K_LW) ? 2'b01 : 2'b00;
                cycle(1'b0, 1'b0, s, m_ctl, {t.name, "/WB"});
            end
            exp_ret = exp_ret + 3'd1;
            chk({t.name, "/state_after"}, 32'(state), 32'd0);
        end
        chk({t.name, "/instret"}, 32'(instret), 32'(exp_ret));
    endtask

    initial begin
        snap_t s, m_ctl;
        m_ctl = '1; m_ctl.alu = '0; m_ctl.src = 1'b0; m_ctl.ext = 1'b0; m_ctl.areg = 1'b0;

        //                 name    op      funct   Z  kind     alu    src ext areg tk idly ddly
        tbl.push_back(mk("add",  6'h00, 6'h20, 0, K_ALU_R, 4'd1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("sub",  6'h00, 6'h22, 0, K_ALU_R, 4'd2,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("sll",  6'h00, 6'h00, 0, K_ALU_R, 4'd7,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("sra",  6'h00, 6'h03, 0, K_ALU_R, 4'd9,  0, 0, 1, 0, 1, 0));
        tbl.push_back(mk("srlv", 6'h00, 6'h06, 0, K_ALU_R, 4'd8,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("nor",  6'h00, 6'h27, 0, K_ALU_R, 4'd10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("sltu", 6'h00, 6'h2B, 0, K_ALU_R, 4'd6,  0, 0, 0, 0, 3, 0));
        tbl.push_back(mk("addi", 6'h08, 6'h00, 0, K_ALU_I, 4'd1,  1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("ori",  6'h0D, 6'h00, 0, K_ALU_I, 4'd4,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lui",  6'h0F, 6'h00, 0, K_ALU_I, 4'd12, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lw",   6'h23, 6'h00, 0, K_LW,    4'd1,  1, 1, 0, 0, 0, 3));
        tbl.push_back(mk("sw",   6'h2B, 6'h00, 0, K_SW,    4'd1,  1, 1, 0, 0, 0, 1));
        tbl.push_back(mk("beqZ", 6'h04, 6'h00, 1, K_BR,    4'd2,  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk("bneZ", 6'h05, 6'h00, 1, K_BR,    4'd2,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("bneN", 6'h05, 6'h00, 0, K_BR,    4'd2,  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk("j",    6'h02, 6'h00, 0, K_J,     4'd0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("jal",  6'h03, 6'h00, 0, K_JAL,   4'd0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("jr",   6'h00, 6'h08, 0, K_JR,    4'd0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("jalr", 6'h00, 6'h09, 0, K_JALR,  4'd0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("bad",  6'h3F, 6'h00, 0, K_BAD,   4'd0,  0, 0, 0, 0, 0, 0));

        rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/state", 32'(state), 32'd0);
        chk("reset/instret", 32'(instret), 32'd0);
        chk("reset/err", 32'(err), 32'd0);
        chk("reset/imem_req", 32'(imem_req), 32'd1);
        rst = 1'b0;
        exp_ret = '0;

        foreach (tbl[i]) run_instr(tbl[i]);

        // Watchdog: four unanswered fetch cycles end in HALT with err set.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = '0; s.ireq = 1'b1;
            cycle(1'b0, 1'b0, s, m_ctl, "tmo/FWAIT");
        end
        s = '0; s.st = 3'd5; s.err = 1'b1;
        cycle(1'b1, 1'b0, s, m_ctl, "tmo/HALT");
        cycle(1'b1, 1'b1, s, m_ctl, "tmo/HALT_hold");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("tmo_rst/state", 32'(state), 32'd0);
        chk("tmo_rst/err", 32'(err), 32'd0);
        chk("tmo_rst/instret", 32'(instret), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        chk("tmo_rst/illegal", 32'(illegal), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle successor to the single-cycle MIPS decoder. The block is a state machine that sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and handshakes with instruction and data memories that have variable latency. It drives the same datapath control signals as the single-cycle decoder, plus per-phase write enables, and adds a memory-timeout watchdog and a retired-instruction counter. It sits between the IR/PC datapath and the memories in the multi-cycle CPU top.

Parameters:
ALUOP_W, 4, ALUOp width; minimum 4; upper bits zero-filled.
TIMEOUT, 255, maximum wait cycles on a memory handshake before err asserts; must be 1..2^16-1.
RET_W, 32, width of the instret counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
Op  in  6  opcode from IR (valid from DECODE onward)
Funct  in  6  funct from IR
Zero  in  1  ALU zero flag, sampled in EXEC
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid
dmem_req  out  1  data access request
dmem_ready  in  1  data access complete
PCWrite  out  1  PC load enable
IRWrite  out  1  IR load enable
RegWrite  out  1  register file write
MemWrite  out  1  data memory write (qualifies dmem_req)
EXTOp  out  1  1 = sign extend
ALUSrc  out  1  1 = ALU B from immediate
AregSel  out  1  1 = ALU A from shamt
ALUOp  out  ALUOP_W  ALU operation
NPCOp  out  2  00 +4, 01 branch, 10 jump (target field), 11 jump register
GPRSel  out  2  00 rd, 01 rt, 10 $31
WDSel  out  2  00 ALU, 01 MEM, 10 PC+4
state  out  3  current state, for debug
instret  out  RET_W  retired instruction count
err  out  1  sticky memory-timeout flag

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5 (6 is reserved for the optional TRAP state).
- Outputs are combinational from state, Op, Funct and Zero. Every enable is 0 outside the cases listed below.
- rst high at an edge: state<=FETCH, instret<=0, err<=0, wait counter<=0. This takes priority over everything, including a handshake pending mid-access.
- FETCH: imem_req=1. When imem_ready=1, IRWrite=1 and PCWrite=1 with NPCOp=00 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: 1 cycle, then go to EXEC. An unrecognised Op/Funct goes back to FETCH and retires as a NOP.
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, nor, xor, slt, sltu, sll, srl, sra, sllv, srlv, jr, jalr.
  - I-type: addi, andi, ori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- ALUOp codes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 NOR, 11 XOR, 12 LUI.
- AregSel=1 only for sll/srl/sra. EXTOp=1 for addi, slti, lw, sw, beq, bne.
- EXEC, ALU ops: ALUOp/ALUSrc valid, then go to WB.
- EXEC, lw/sw: ALUOp=ADD, ALUSrc=1, then go to MEM.
- EXEC, beq/bne: ALUOp=SUB. PCWrite=1 with NPCOp=01 when (beq&Zero)|(bne&~Zero). Then go to FETCH; the instruction retires.
- EXEC, j/jal: PCWrite=1, NPCOp=10. jr/jalr: PCWrite=1, NPCOp=11.
- EXEC, jal/jalr: also RegWrite=1, WDSel=10, GPRSel=10 (jalr writes rd; GPRSel=00). All jumps then go to FETCH and retire.
- MEM: dmem_req=1, MemWrite=sw. On dmem_ready: sw goes to FETCH and retires; lw goes to WB.
- WB: RegWrite=1. GPRSel=01 for I-type, 00 for R-type. WDSel=01 for lw, else 00. Then go to FETCH and retire.
- instret increments by 1 on each retiring transition into FETCH and wraps from all-ones to 0.
- Watchdog: the wait counter increments each cycle that req=1 and ready=0, and clears on ready or on leaving the state. When the counter reaches TIMEOUT: err<=1, state<=HALT.
- HALT: all enables 0, no requests. Only rst exits HALT.
- ready asserted in the same cycle the counter hits TIMEOUT: ready wins and err stays 0.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unrecognised instruction in DECODE goes to TRAP (state=6). Output illegal=1 (extra 1-bit port, sticky until rst), all enables 0, and the instruction does not retire.
- Undefined: the illegal port is absent and unrecognised instructions retire as a NOP.

Test Plan:
- add after rst, imem_ready=1 immediately, Op=0 Funct=100000 -> states 0,1,2,4,0; RegWrite=1 only in WB; ALUOp=1; instret=1.
- lw with dmem_ready delayed 3 cycles -> MEM held 4 cycles, dmem_req=1 throughout, WB has WDSel=01 GPRSel=01, total 8 cycles.
- beq with Zero=1, then bne with Zero=1 -> PCWrite/NPCOp=01 in EXEC only for beq; both retire, instret=2.
- jal -> EXEC has PCWrite=1 NPCOp=10 RegWrite=1 GPRSel=10 WDSel=10; next state FETCH.
- TIMEOUT=4, imem_ready held 0 -> err=1 and state=5 after 4 wait cycles; rst returns state to 0 and err to 0.
- Op=111111 with ILLEGAL_TRAP_EN -> state 6, illegal=1, instret unchanged; without the macro -> NOP, instret+1.
